// File: rtl/gf2m_power_engine.sv
// +--------------------------------------------------------------------------+
// | gf2m_power_engine: iterative y = x^e over GF(2^M), left-to-right          |
// | square-and-multiply in polynomial basis, valid/ready on both sides.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module gf2m_power_engine #(
    parameter int         M    = 6,
    parameter logic [M:0] POLY = 7'h43
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] x,
    input  logic [M-1:0] e,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] y,
    output logic         busy
);

    localparam int         CW      = (M > 1) ? $clog2(M) : 1;
    localparam logic [M-1:0] ONE     = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M-1:0] INV_EXP = {{(M-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0] CNT_TOP = CW'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [M-1:0]  base_q, base_d;
    logic [M-1:0]  exp_q, exp_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  y_q, y_d;
    logic [M-1:0]  sq_w, step_w;

    // MSB-first interleaved multiply: reduction folded into every shift keeps r within M bits.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY[M-1:0] : '0);
            if (b[i]) begin
                r = r ^ a;
            end
        end
        return r;
    endfunction

    always_comb begin
        sq_w   = gf_mul(acc_q, acc_q);
        step_w = exp_q[cnt_q] ? gf_mul(sq_w, base_q) : sq_w;
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        exp_d   = exp_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d  = x;
                    exp_d   = inv ? INV_EXP : e;
                    acc_d   = ONE;
                    cnt_d   = CNT_TOP;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = step_w;
                if (cnt_q == '0) begin
                    y_d     = step_w;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            exp_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign y         = y_q;

endmodule

`default_nettype wire

// File: tb/tb_gf2m_power_engine.sv
// +--------------------------------------------------------------------------+
// | tb_gf2m_power_engine: scoreboard bench for the GF(2^M) power engine,     |
// | default field plus M=8 (AES) and M=4 instances.                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_gf2m_power_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference arithmetic: full carry-less product then long-division reduction.
    function automatic int gmul(input int a, input int b, input int m, input int poly);
        int p = 0;
        for (int i = 0; i < m; i++) if (b[i]) p ^= (a << i);
        for (int k = 2 * m - 2; k >= m; k--) if (p[k]) p ^= (poly << (k - m));
        return p;
    endfunction

    function automatic int gpow(input int xv, input int ev, input int m, input int poly);
        int r = 1;
        for (int i = 0; i < ev; i++) r = gmul(r, xv, m, poly);
        return r;
    endfunction

    function automatic int ginv(input int xv, input int m, input int poly);
        for (int c = 1; c < (1 << m); c++) if (gmul(c, xv, m, poly) == 1) return c;
        return 0;
    endfunction

    // ---------------- M = 6 (default) ----------------
    logic       in_valid, in_ready, inv, out_valid, out_ready, busy;
    logic [5:0] x, e, y, pend6;
    logic [5:0] q6[$];
    int         acc6 = 0;

    gf2m_power_engine dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .e(e), .inv(inv), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    always @(posedge clk) if (rst_n && in_valid && in_ready) begin
        q6.push_back(pend6);
        acc6 <= acc6 + 1;
    end

    always @(negedge clk) if (rst_n && out_valid) begin
        if (q6.size() == 0) check("m6_unexpected_out_valid", 1, 0);
        else begin
            check("m6_y", int'(y), int'(q6[0]));
            if (out_ready) void'(q6.pop_front());
        end
    end

    task automatic send6(input int xv, input int ev, input bit iv, input int expv);
        int  n0 = acc6;
        bit  ok = 1'b0;
        x = 6'(xv); e = 6'(ev); inv = iv; pend6 = 6'(expv); in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (acc6 != n0) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!ok) check("m6_accept_timeout", 0, 1);
    endtask

    task automatic drain6();
        for (int k = 0; k < 2000 && q6.size() != 0; k++) begin @(posedge clk); #1; end
        if (q6.size() != 0) check("m6_drain_timeout", q6.size(), 0);
    endtask

    // ---------------- M = 8, AES polynomial ----------------
    logic       iv8, ir8, inv8, ov8, busy8;
    logic       or8 = 1'b1;
    logic [7:0] x8, e8, y8, pend8;
    logic [7:0] q8[$];
    int         acc8 = 0;

    gf2m_power_engine #(.M(8), .POLY(9'h11B)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .x(x8), .e(e8), .inv(inv8), .out_valid(ov8), .out_ready(or8),
        .y(y8), .busy(busy8)
    );

    always @(posedge clk) if (rst_n && iv8 && ir8) begin
        q8.push_back(pend8);
        acc8 <= acc8 + 1;
    end

    always @(negedge clk) if (rst_n && ov8) begin
        if (q8.size() == 0) check("m8_unexpected_out_valid", 1, 0);
        else begin
            check("m8_y", int'(y8), int'(q8[0]));
            if (or8) void'(q8.pop_front());
        end
    end

    task automatic send8(input int xv, input int ev, input bit iv, input int expv);
        int n0 = acc8;
        bit ok = 1'b0;
        x8 = 8'(xv); e8 = 8'(ev); inv8 = iv; pend8 = 8'(expv); iv8 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (acc8 != n0) begin ok = 1'b1; break; end
        end
        iv8 = 1'b0;
        if (!ok) check("m8_accept_timeout", 0, 1);
    endtask

    // ---------------- M = 4, x^4+x+1 ----------------
    logic       iv4, ir4, inv4, ov4, busy4;
    logic       or4 = 1'b1;
    logic [3:0] x4, e4, y4, pend4;
    logic [3:0] q4[$];
    int         acc4 = 0;

    gf2m_power_engine #(.M(4), .POLY(5'h13)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .x(x4), .e(e4), .inv(inv4), .out_valid(ov4), .out_ready(or4),
        .y(y4), .busy(busy4)
    );

    always @(posedge clk) if (rst_n && iv4 && ir4) begin
        q4.push_back(pend4);
        acc4 <= acc4 + 1;
    end

    always @(negedge clk) if (rst_n && ov4) begin
        if (q4.size() == 0) check("m4_unexpected_out_valid", 1, 0);
        else begin
            check("m4_y", int'(y4), int'(q4[0]));
            if (or4) void'(q4.pop_front());
        end
    end

    task automatic send4(input int xv, input int ev, input bit iv, input int expv);
        int n0 = acc4;
        bit ok = 1'b0;
        x4 = 4'(xv); e4 = 4'(ev); inv4 = iv; pend4 = 4'(expv); iv4 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (acc4 != n0) begin ok = 1'b1; break; end
        end
        iv4 = 1'b0;
        if (!ok) check("m4_accept_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int n0;
        bit seen;
        int xv, ev;
        rst_n = 1'b0;
        in_valid = 1'b0; x = '0; e = '0; inv = 1'b0; out_ready = 1'b1;
        iv8 = 1'b0; x8 = '0; e8 = '0; inv8 = 1'b0;
        iv4 = 1'b0; x4 = '0; e4 = '0; inv4 = 1'b0;
        pend6 = '0; pend8 = '0; pend4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y", int'(y), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_in_ready", int'(in_ready), 1);

        // S-box exponent with latency measurement: result visible after M edges past accept
        send6(6'h02, 6'h26, 1'b0, 6'h1B);
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency_edges", lat, 6);
        drain6();

        send6(6'h20, 2, 1'b0, 6'h30);
        send6(6'h02, 6, 1'b0, 6'h03);
        send6(6'h37, 1, 1'b0, 6'h37);
        send6(6'h00, 0, 1'b0, 6'h01);
        send6(6'h00, 5, 1'b0, 6'h00);
        send6(6'h15, 63, 1'b0, 6'h01);
        send6(6'h02, 6'h15, 1'b1, 6'h21);
        send6(6'h00, 6'h15, 1'b1, 6'h00);
        drain6();

        for (int i = 1; i < 64; i++) send6(i, $urandom_range(0, 63), 1'b1, ginv(i, 6, 'h43));
        drain6();

        // Backpressure: result held, second request waits upstream
        out_ready = 1'b0;
        send6(6'h05, 6'h11, 1'b0, gpow(5, 17, 6, 'h43));
        for (int k = 0; k < 20 && !out_valid; k++) begin @(posedge clk); #1; end
        check("bp_out_valid", int'(out_valid), 1);
        n0 = acc6;
        x = 6'h07; e = 6'h03; inv = 1'b0; pend6 = 6'(gpow(7, 3, 6, 'h43)); in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_busy", int'(busy), 1);
        end
        check("bp_no_accept", acc6 - n0, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && acc6 == n0; k++) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        check("bp_second_accept", acc6 - n0, 1);
        drain6();

        // Inputs changing mid-run must not disturb the operation
        send6(6'h03, 5, 1'b0, gpow(3, 5, 6, 'h43));
        x = 6'h3F; e = 6'h00; inv = 1'b1;
        drain6();

        // Asynchronous reset at RUN cycle 3 aborts silently
        send6(6'h09, 6'h2A, 1'b0, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        q6.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("abort_no_result", int'(seen), 0);
        send6(6'h09, 6'h2A, 1'b0, gpow(9, 42, 6, 'h43));
        drain6();

        for (int i = 0; i < 10; i++) begin
            xv = $urandom_range(0, 63); ev = $urandom_range(0, 63);
            send6(xv, ev, 1'b0, gpow(xv, ev, 6, 'h43));
        end
        drain6();

        // Parameter sweep
        send8(8'h53, 8'h00, 1'b1, 8'hCA);
        for (int i = 0; i < 10; i++) begin
            xv = $urandom_range(0, 255); ev = $urandom_range(0, 255);
            send8(xv, ev, 1'b0, gpow(xv, ev, 8, 'h11B));
        end
        send4(4'h2, 4'h0, 1'b1, 4'h9);
        for (int i = 0; i < 10; i++) begin
            xv = $urandom_range(0, 15); ev = $urandom_range(0, 15);
            send4(xv, ev, 1'b0, gpow(xv, ev, 4, 'h13));
        end
        for (int k = 0; k < 200 && (q8.size() != 0 || q4.size() != 0); k++) begin
            @(posedge clk); #1;
        end
        check("sweep_drain", q8.size() + q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
